// File: rtl/streamer_pkg.sv
// Shared types for the ROM-to-UART byte streamer: FSM states, byte index
// and the default program-memory address width.
package streamer_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 13;
  localparam int unsigned IDX_W          = 2;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_LAST = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MEMWAIT,
    ST_LOAD,
    ST_SEND,
    ST_GUARD,
    ST_GAP
  } state_e;

  // Little-endian byte lane select: index 0 is the least significant byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input idx_t idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rom_uart_streamer.sv
// Streams an inclusive range of 32-bit ROM words to a byte-wide UART
// transmitter, least significant byte first, with optional inter-byte gap.
module rom_uart_streamer
  import streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned TX_GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic [7:0]        tx_byte,
  output logic              tx_send,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  // A zero gap still spends one clock in GAP, so the counter spans max(TX_GAP,1).
  localparam int unsigned     GAP_CYCLES = (TX_GAP > 0) ? TX_GAP : 1;
  localparam int unsigned     GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W-1:0] last_q,  last_d;
  logic [31:0]       word_q,  word_d;
  idx_t              idx_q,   idx_d;
  logic [GAP_W-1:0]  gap_q,   gap_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    word_d  = word_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    tx_send = 1'b0;
    done    = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            addr_d  = first_addr;
            last_d  = last_addr;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH:   state_d = ST_MEMWAIT;
        ST_MEMWAIT: state_d = ST_LOAD;
        ST_LOAD: begin
          word_d  = mem_data;
          idx_d   = '0;
          state_d = ST_SEND;
        end
        ST_SEND: begin
          if (tx_ready) begin
            tx_send = 1'b1;
            state_d = ST_GUARD;
          end
        end
        ST_GUARD: begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (idx_q != IDX_LAST) begin
              idx_d   = idx_q + idx_t'(1);
              state_d = ST_SEND;
            end else if (addr_q != last_q) begin
              // Natural ADDR_W-bit wrap lets a range cross the top of memory.
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_FETCH;
            end else begin
              done    = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign mem_addr = addr_q;
  assign tx_byte  = byte_sel(word_q, idx_q);
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/rom_uart_streamer.md
ROM_UART_STREAMER -- requirements
Module: rom_uart_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, word-address width of program memory.
REQ-002 SHALL have parameter TX_GAP, default 0, extra idle clocks inserted between bytes.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  level; sampled in IDLE only; begins a dump.
REQ-006 abort  input  1  level; terminates dump without done pulse.
REQ-007 first_addr  input  ADDR_W  first word address; sampled on accepted start.
REQ-008 last_addr  input  ADDR_W  last word address, inclusive; sampled on accepted start.
REQ-009 mem_addr  output  ADDR_W  word address to synchronous ROM.
REQ-010 mem_data  input  32  ROM read data, valid exactly one clock after mem_addr is presented.
REQ-011 tx_byte  output  8  byte to UART transmitter; stable while tx_send high and until next byte.
REQ-012 tx_send  output  1  one-clock pulse requesting transmission of tx_byte.
REQ-013 tx_ready  input  1  level; high while transmitter idle and able to accept.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-clock pulse after final byte of last_addr accepted by transmitter.

Function
REQ-016 SHALL implement states IDLE, FETCH, MEMWAIT, LOAD, SEND, GUARD, GAP.
REQ-017 IDLE: start=1 -> latch first_addr into address counter, latch last_addr, go FETCH; else stay.
REQ-018 FETCH: drive mem_addr = address counter; go MEMWAIT next clock.
REQ-019 MEMWAIT: go LOAD; LOAD: capture mem_data into 32-bit word register, byte index = 0, go SEND.
REQ-020 Byte order SHALL be little-endian: index 0..3 -> word[7:0], [15:8], [23:16], [31:24]; no overlapping slices.
REQ-021 SEND: when tx_ready=1, assert tx_send for exactly one clock with tx_byte = selected byte, go GUARD; when tx_ready=0, wait with tx_send=0.
REQ-022 GUARD: one clock ignoring tx_ready (transmitter handshake latency), then GAP.
REQ-023 GAP: count TX_GAP clocks (zero -> single pass-through clock), then: index<3 -> index+1, SEND; index=3 and address counter != last_addr -> counter+1, FETCH; index=3 and counter == last_addr -> pulse done, IDLE.
REQ-024 Address counter SHALL wrap modulo 2^ADDR_W; last_addr < first_addr therefore dumps across wrap to last_addr.
REQ-025 first_addr == last_addr SHALL dump exactly 4 bytes.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on next edge, tx_send=0 that cycle, no done; abort has priority over start and over tx_ready.
REQ-027 start while busy SHALL be ignored; start and abort both high in IDLE -> stay IDLE.
REQ-028 tx_send SHALL never be asserted in two consecutive clocks; at most one pulse per byte.
REQ-029 Per-byte throughput: SEND-to-SEND minimum 2+max(TX_GAP,1) clocks plus transmitter busy time.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, mem_addr=0, tx_byte=0, tx_send=0, busy=0, done=0, word register=0, index=0.
REQ-031 Reset mid-dump SHALL discard all progress; no done pulse on release.
REQ-032 Reset deassertion is synchronised externally; block leaves IDLE only on a start sampled after release.

Structure
REQ-033 State enum and byte-index width SHALL live in shared package streamer_pkg; ADDR_W default constant there too.
REQ-034 Single module, no sub-module; ROM and uart_tx_8n1 instantiated by parent.

Verification
REQ-035 ROM[5]=0x44332211, first=last=5, tx_ready always 1 -> tx_send pulses carry 0x11,0x22,0x33,0x44, then one done pulse, busy low.
REQ-036 first=0x1FFE, last=0x0001, ADDR_W=13 -> mem_addr sequence 0x1FFE,0x1FFF,0x0000,0x0001; 16 bytes; one done.
REQ-037 tx_ready held low 100 clocks in SEND of byte 2 -> no tx_send during stall; byte 0x33 sent once after tx_ready rises.
REQ-038 abort asserted in GUARD after byte 1 -> IDLE next edge, no further tx_send, no done; new start restarts at first_addr.
REQ-039 rst pulsed low mid-LOAD -> all outputs zero asynchronously; start held high during busy ignored (no restart until IDLE).
REQ-040 TX_GAP=3 -> exactly 3 idle clocks in GAP between GUARD and next SEND, checked by cycle counter.
